// File: rtl/commit_monitor.sv
// Purpose    : retirement monitor; counts RUN/DRAIN cycles and retired instructions,
//              detects the halt write (HALT_VAL to x[HALT_REG]), drains, then flags done/timeout.
// Latency    : every output is registered; effects of inputs sampled at edge k are visible after edge k.
// Backpressure: none; this is a passive observer, so commits are never stalled.
//
// Ports:
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   start              : single-cycle arm/restart pulse (honoured in IDLE, DONE, TIMEOUT)
//   commit_valid/we    : per-lane retire / architectural-write flags
//   commit_rd/data     : per-lane destination (5 bits) and write value (32 bits), lane i at [i*W +: W]
//   cycle_cnt/instr_cnt: saturating counters of RUN+DRAIN cycles and retired instructions
//   halt_cycle/instr   : counter snapshot taken on the halting edge
//   state              : IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4
//   done/timeout       : high while in DONE / TIMEOUT
module commit_monitor #(
   parameter int          COMMIT_WIDTH = 2,
   parameter int          CNT_WIDTH    = 32,
   parameter int          HALT_REG     = 31,
   parameter logic [31:0] HALT_VAL     = 32'h000000FF,
   parameter int          MAX_CYCLES   = 2000,
   parameter int          DRAIN_CYCLES = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [COMMIT_WIDTH-1:0]   commit_valid,
   input  logic [COMMIT_WIDTH-1:0]   commit_we,
   input  logic [COMMIT_WIDTH*5-1:0] commit_rd,
   input  logic [COMMIT_WIDTH*32-1:0] commit_data,
   output logic [CNT_WIDTH-1:0]      cycle_cnt,
   output logic [CNT_WIDTH-1:0]      instr_cnt,
   output logic [CNT_WIDTH-1:0]      halt_cycle,
   output logic [CNT_WIDTH-1:0]      halt_instr,
   output logic [2:0]                state,
   output logic                      done,
   output logic                      timeout
);

   localparam int N_W   = $clog2(COMMIT_WIDTH + 1);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_DRAIN   = 3'd2,
      S_DONE    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cycle_cnt;
   logic [CNT_WIDTH-1:0] r_instr_cnt;
   logic [CNT_WIDTH-1:0] r_halt_cycle;
   logic [CNT_WIDTH-1:0] r_halt_instr;
   logic [DRN_W-1:0]     r_drain_cnt;
   logic                 r_done;
   logic                 r_timeout;

   state_t               w_nxt_state;
   logic [CNT_WIDTH-1:0] w_nxt_cycle;
   logic [CNT_WIDTH-1:0] w_nxt_instr;
   logic [CNT_WIDTH-1:0] w_nxt_halt_cycle;
   logic [CNT_WIDTH-1:0] w_nxt_halt_instr;
   logic [DRN_W-1:0]     w_nxt_drain;

   logic                 w_hit;
   logic [N_W-1:0]       w_n;
   logic [CNT_WIDTH-1:0] w_cycle_inc;
   logic [CNT_WIDTH-1:0] w_instr_inc;
   logic                 w_wdog;

   // Add with clamp at all-ones; one spare bit catches the carry out.
   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [N_W-1:0]       b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + (CNT_WIDTH+1)'(b);
      return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   // Halt detection and retire popcount. HALT_REG==0 can never signal completion
   // because x0 is hardwired, so the hit is suppressed outright in that case.
   always_comb begin
      w_hit = 1'b0;
      w_n   = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_n = w_n + N_W'(commit_valid[i]);
         if ((HALT_REG != 0) && commit_valid[i] && commit_we[i] &&
             (commit_rd[i*5 +: 5] == 5'(HALT_REG)) &&
             (commit_data[i*32 +: 32] == HALT_VAL))
            w_hit = 1'b1;
      end
   end

   assign w_cycle_inc = sat_add(r_cycle_cnt, N_W'(1));
   assign w_instr_inc = sat_add(r_instr_cnt, w_n);
   // Compared on the unclamped sum in a wide domain so a MAX_CYCLES beyond the
   // counter range can never alias onto a truncated value.
   assign w_wdog      = (64'(r_cycle_cnt) + 64'd1) == 64'(MAX_CYCLES);

   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_cycle      = r_cycle_cnt;
      w_nxt_instr      = r_instr_cnt;
      w_nxt_halt_cycle = r_halt_cycle;
      w_nxt_halt_instr = r_halt_instr;
      w_nxt_drain      = r_drain_cnt;
      case (r_state)
         S_IDLE, S_DONE, S_TIMEOUT: begin
            if (start) begin
               w_nxt_state      = S_RUN;
               w_nxt_cycle      = '0;
               w_nxt_instr      = '0;
               w_nxt_halt_cycle = '0;
               w_nxt_halt_instr = '0;
               w_nxt_drain      = '0;
            end
         end
         S_RUN: begin
            w_nxt_cycle = w_cycle_inc;
            w_nxt_instr = w_instr_inc;
            // Hit has priority over the watchdog on the same edge.
            if (w_hit) begin
               w_nxt_state      = S_DRAIN;
               w_nxt_halt_cycle = w_cycle_inc;
               w_nxt_halt_instr = w_instr_inc;
               w_nxt_drain      = '0;
            end else if (w_wdog) begin
               w_nxt_state = S_TIMEOUT;
            end
         end
         S_DRAIN: begin
            w_nxt_cycle = w_cycle_inc;
            w_nxt_instr = w_instr_inc;
            w_nxt_drain = r_drain_cnt + DRN_W'(1);
            if (r_drain_cnt == DRN_W'(DRAIN_CYCLES - 1))
               w_nxt_state = S_DONE;
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cycle_cnt  <= '0;
         r_instr_cnt  <= '0;
         r_halt_cycle <= '0;
         r_halt_instr <= '0;
         r_drain_cnt  <= '0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_cycle_cnt  <= w_nxt_cycle;
         r_instr_cnt  <= w_nxt_instr;
         r_halt_cycle <= w_nxt_halt_cycle;
         r_halt_instr <= w_nxt_halt_instr;
         r_drain_cnt  <= w_nxt_drain;
         r_done       <= (w_nxt_state == S_DONE);
         r_timeout    <= (w_nxt_state == S_TIMEOUT);
      end
   end

   assign cycle_cnt  = r_cycle_cnt;
   assign instr_cnt  = r_instr_cnt;
   assign halt_cycle = r_halt_cycle;
   assign halt_instr = r_halt_instr;
   assign state      = r_state;
   assign done       = r_done;
   assign timeout    = r_timeout;

endmodule

// File: tb/tb_commit_monitor.sv
module tb_commit_monitor;

   localparam int DRN = 10;

   // Reference state: phase (0..4), counters as plain integers, edges since halt.
   typedef struct {
      int     st;
      longint cyc;
      longint ins;
      longint hc;
      longint hi;
      int     since;
   } mdl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  cv = '0;
   logic [1:0]  cwe = '0;
   logic [9:0]  crd = '0;
   logic [63:0] cdat = '0;

   logic [31:0] a_cyc, a_ins, a_hc, a_hi;
   logic [2:0]  a_st;
   logic        a_done, a_to;
   logic [3:0]  b_cyc, b_ins, b_hc, b_hi;
   logic [2:0]  b_st;
   logic        b_done, b_to;

   int   n_cmp = 0;
   int   n_fail = 0;
   mdl_t ma, mb;
   mdl_t qa[$];
   mdl_t qb[$];

   always #5 clk = ~clk;

   commit_monitor #(.COMMIT_WIDTH(2), .CNT_WIDTH(32), .HALT_REG(31), .HALT_VAL(32'hFF),
                    .MAX_CYCLES(20), .DRAIN_CYCLES(DRN)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .commit_valid(cv), .commit_we(cwe),
      .commit_rd(crd), .commit_data(cdat), .cycle_cnt(a_cyc), .instr_cnt(a_ins),
      .halt_cycle(a_hc), .halt_instr(a_hi), .state(a_st), .done(a_done), .timeout(a_to));

   commit_monitor #(.COMMIT_WIDTH(2), .CNT_WIDTH(4), .HALT_REG(31), .HALT_VAL(32'hFF),
                    .MAX_CYCLES(2000), .DRAIN_CYCLES(DRN)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .commit_valid(cv), .commit_we(cwe),
      .commit_rd(crd), .commit_data(cdat), .cycle_cnt(b_cyc), .instr_cnt(b_ins),
      .halt_cycle(b_hc), .halt_instr(b_hi), .state(b_st), .done(b_done), .timeout(b_to));

   function automatic longint clampv(longint v, longint maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Behavioural model of one retire edge.
   function automatic mdl_t mstep(mdl_t m, bit s, int n, bit hit, longint maxv, longint maxc);
      mdl_t r = m;
      if (m.st == 0 || m.st == 3 || m.st == 4) begin
         if (s) r = '{st: 1, default: 0};
      end else if (m.st == 1) begin
         r.cyc = clampv(m.cyc + 1, maxv);
         r.ins = clampv(m.ins + n, maxv);
         if (hit) begin
            r.st = 2; r.hc = r.cyc; r.hi = r.ins; r.since = 0;
         end else if (m.cyc + 1 == maxc) begin
            r.st = 4;
         end
      end else if (m.st == 2) begin
         r.cyc   = clampv(m.cyc + 1, maxv);
         r.ins   = clampv(m.ins + n, maxv);
         r.since = m.since + 1;
         if (r.since == DRN) r.st = 3;
      end
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic snap(input string tag, input mdl_t e, input int st, input longint cyc,
                       input longint ins, input longint hc, input longint hi,
                       input bit dn, input bit to);
      n_cmp++;
      if (st != e.st || cyc != e.cyc || ins != e.ins || hc != e.hc || hi != e.hi ||
          dn != (e.st == 3) || to != (e.st == 4)) begin
         n_fail++;
         $display("FAIL scoreboard_%s @%0t: got st=%0d cyc=%0d ins=%0d hc=%0d hi=%0d done=%0d to=%0d expected st=%0d cyc=%0d ins=%0d hc=%0d hi=%0d",
                  tag, $time, st, cyc, ins, hc, hi, dn, to, e.st, e.cyc, e.ins, e.hc, e.hi);
      end
   endtask

   // Monitor: one expected snapshot per clocked edge, compared away from the edge.
   initial begin
      mdl_t e;
      forever begin
         @(negedge clk);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            snap("A", e, int'(a_st), a_cyc, a_ins, a_hc, a_hi, a_done, a_to);
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            snap("B", e, int'(b_st), b_cyc, b_ins, b_hc, b_hi, b_done, b_to);
         end
      end
   end

   task automatic step(input bit s, input bit [1:0] v, input bit [1:0] we,
                       input bit [4:0] rd0, input bit [4:0] rd1,
                       input bit [31:0] d0, input bit [31:0] d1);
      bit hit;
      int n;
      start = s; cv = v; cwe = we; crd = {rd1, rd0}; cdat = {d1, d0};
      n   = $countones(v);
      hit = (v[0] && we[0] && rd0 == 5'd31 && d0 == 32'hFF) ||
            (v[1] && we[1] && rd1 == 5'd31 && d1 == 32'hFF);
      ma = mstep(ma, s, n, hit, 64'd4294967295, 20);
      mb = mstep(mb, s, n, hit, 15, 2000);
      qa.push_back(ma);
      qb.push_back(mb);
      @(posedge clk);
      @(negedge clk);
      #1;
      start = 1'b0; cv = '0; cwe = '0;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 2'b00, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic go();
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic two();
      step(0, 2'b11, 2'b11, 5'd1, 5'd2, 32'h10, 32'h20);
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      ma = '{default: 0};
      mb = '{default: 0};
      rst_n = 1'b1;
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", a_st, 0);
      chk("reset_cycle", a_cyc, 0);
      chk("reset_flags", {a_done, a_to}, 0);
      chk("reset_b_instr", b_ins, 0);
      rst_n = 1'b1;

      // Basic halt: 5 cycles of 2 commits, hit on lane1 in cycle 6 with lane0 valid.
      go();
      repeat (5) two();
      step(0, 2'b11, 2'b10, 5'd3, 5'd31, 32'h1, 32'hFF);
      chk("halt_state", a_st, 2);
      chk("halt_cycle", a_hc, 6);
      chk("halt_instr", a_hi, 12);
      idle(9);
      chk("drain_not_done", a_done, 0);
      idle(1);
      chk("done_flag", a_done, 1);
      chk("done_cycle", a_cyc, 16);
      chk("done_instr", a_ins, 12);
      chk("b_cycle_sat", b_cyc, 15);
      idle(3);
      chk("done_frozen", a_cyc, 16);

      // Restart from DONE, then start in RUN is ignored.
      go();
      chk("restart_state", a_st, 1);
      chk("restart_cnt", a_cyc + a_ins + a_hc + a_hi, 0);
      two(); two();
      step(1, 2'b01, 2'b00, 0, 0, 0, 0);
      chk("start_in_run_cycle", a_cyc, 3);
      chk("start_in_run_instr", a_ins, 5);

      // Near misses: x31=FE, x30=FF, x31=FF with we=0 (plus an invalid lane with a hit pattern).
      step(0, 2'b11, 2'b11, 5'd31, 5'd30, 32'hFE, 32'hFF);
      step(0, 2'b01, 2'b10, 5'd31, 5'd31, 32'hFF, 32'hFF);
      chk("nearmiss_state", a_st, 1);
      chk("nearmiss_instr", a_ins, 8);

      // Watchdog: cycle_cnt is 5 here; TIMEOUT on the 20th RUN edge.
      idle(14);
      chk("wdog_pre_state", a_st, 1);
      idle(1);
      chk("wdog_state", a_st, 4);
      chk("wdog_flag", a_to, 1);
      chk("wdog_cycle", a_cyc, 20);
      chk("wdog_no_done", a_done, 0);
      idle(2);
      chk("wdog_sticky", a_st, 4);

      // Hit on the watchdog edge wins.
      go();
      idle(19);
      step(0, 2'b01, 2'b01, 5'd31, 5'd0, 32'hFF, 32'h0);
      chk("hit_on_limit_state", a_st, 2);
      chk("hit_on_limit_hc", a_hc, 20);
      chk("hit_on_limit_to", a_to, 0);
      idle(10);
      chk("hit_on_limit_done", a_cyc, 30);

      // Dual hit latches once; later hit in DRAIN ignored; async reset mid-DRAIN.
      go();
      two(); two();
      step(0, 2'b11, 2'b11, 5'd31, 5'd31, 32'hFF, 32'hFF);
      chk("dual_hc", a_hc, 3);
      chk("dual_hi", a_hi, 6);
      step(0, 2'b11, 2'b11, 5'd31, 5'd31, 32'hFF, 32'hFF);
      chk("rehit_hi", a_hi, 6);
      chk("rehit_instr", a_ins, 8);
      idle(3);
      rst_n = 1'b0;
      #1;
      chk("arst_state", a_st, 0);
      chk("arst_a_cnt", a_cyc + a_ins + a_hc + a_hi, 0);
      chk("arst_b_cnt", b_cyc + b_ins + b_hc + b_hi, 0);
      chk("arst_flags", {a_done, a_to, b_done, b_to}, 0);
      ma = '{default: 0};
      mb = '{default: 0};
      rst_n = 1'b1;

      // Saturation on the 4-bit instance.
      go();
      repeat (18) two();
      chk("sat_b_instr", b_ins, 15);
      chk("sat_b_cycle", b_cyc, 15);
      chk("sat_a_instr", a_ins, 36);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bit        s;
         bit [1:0]  v, we;
         bit [4:0]  rd [2];
         bit [31:0] d  [2];
         s = ($urandom_range(0, 29) == 0);
         for (int l = 0; l < 2; l++) begin
            v[l]  = ($urandom_range(0, 3) != 0);
            we[l] = 1'($urandom_range(0, 1));
            rd[l] = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            d[l]  = ($urandom_range(0, 2) == 0) ? 32'hFF :
                    (($urandom_range(0, 1) == 0) ? 32'hFE : $urandom);
         end
         step(s, v, we, rd[0], rd[1], d[0], d[1]);
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      idle(2);
      chk("queue_empty", qa.size() + qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

In-design retirement monitor, downstream of the commit stage. It counts cycles and retired instructions per commit lane and detects program completion: an architectural write of 0xFF to x31. After completion it drains for a fixed number of cycles, then raises `done`. A watchdog raises `timeout` if completion never arrives. It gives the SoC and the bench registered performance counters without peeking into the PRF hierarchy.

## Interface
- `COMMIT_WIDTH`, 2: commit lanes per cycle.
- `CNT_WIDTH`, 32: width of all counters.
- `HALT_REG`, 31: architectural rd that signals completion.
- `HALT_VAL`, 32'h000000FF: value that signals completion.
- `MAX_CYCLES`, 2000: watchdog limit in RUN cycles; must be ≥ 2.
- `DRAIN_CYCLES`, 10: settle cycles after halt; must be ≥ 1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle arm/restart pulse.
- `commit_valid` in COMMIT_WIDTH: lane i retired an instruction this cycle.
- `commit_we` in COMMIT_WIDTH: lane i writes an architectural rd.
- `commit_rd` in COMMIT_WIDTH×5: architectural destination of lane i.
- `commit_data` in COMMIT_WIDTH×32: value written by lane i.
- `cycle_cnt` out CNT_WIDTH: cycles spent in RUN plus DRAIN.
- `instr_cnt` out CNT_WIDTH: instructions retired in RUN plus DRAIN.
- `halt_cycle` out CNT_WIDTH: cycle_cnt value at halt.
- `halt_instr` out CNT_WIDTH: instr_cnt value at halt, including the halting cycle's commits.
- `state` out 3: IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4.
- `done` out 1: high while in DONE.
- `timeout` out 1: high while in TIMEOUT.

## Operation
- Reset (rst_n low, asynchronous): state=IDLE; every counter, halt_cycle, halt_instr, done and timeout = 0.
- Lane hit: `commit_valid[i] & commit_we[i] & commit_rd[i]==HALT_REG & commit_data[i]==HALT_VAL`. The hit test is forced false when HALT_REG==0.
- Retire count n = popcount(commit_valid), taken from 0..COMMIT_WIDTH. Valid lanes with rd=x0 or we=0 still count.
- IDLE: commits are ignored. On `start`: cycle_cnt=0, instr_cnt=0, halt_cycle=0, halt_instr=0, go to RUN.
- RUN, each edge: cycle_cnt+=1, instr_cnt+=n.
  - Any lane hit: go to DRAIN. Latch halt_cycle=cycle_cnt+1 and halt_instr=instr_cnt+n. Clear the drain counter. Multiple hitting lanes latch once.
  - Else, if cycle_cnt+1==MAX_CYCLES: go to TIMEOUT.
  - A hit and the watchdog limit on the same edge: the hit wins (DRAIN).
- DRAIN, each edge: cycle_cnt+=1, instr_cnt+=n, drain counter+=1. Further hits are ignored. On the edge where the drain counter == DRAIN_CYCLES-1, go to DONE.
- DONE and TIMEOUT: all counters frozen and the state is sticky. `start` restarts exactly as from IDLE.
- `start` in RUN or DRAIN is ignored.
- Counters saturate at all-ones and never wrap. instr_cnt adds with saturation.
- Reset mid-operation returns to the reset values immediately; no partial state survives.

## Timing
- All outputs are registered; no combinational path from input to output.
- `start` sampled at edge k: RUN is visible after edge k; counters read 0 after edge k.
- A hit sampled at edge h: state=DRAIN and halt_* are valid after edge h.
- done rises exactly DRAIN_CYCLES edges after h.
- Final cycle_cnt = halt_cycle + DRAIN_CYCLES.
- Watchdog: with no hit, TIMEOUT is entered at the MAX_CYCLES-th RUN edge, with cycle_cnt=MAX_CYCLES.
- done and timeout are never high together.

## Test plan
- Basic halt: reset, start, then 2 commits/cycle for 5 cycles (no hits); cycle 6 lane1 writes x31=0xFF with lane0 valid; then 0 commits.
  - Required: halt_cycle=6, halt_instr=12, DONE 10 edges later, cycle_cnt=16, instr_cnt=12.
- Near-miss writes: x31=0xFE, x30=0xFF, and x31=0xFF with we=0.
  - Required: no DRAIN; instr_cnt counts all three.
- Watchdog: MAX_CYCLES=20, start, no hit.
  - Required: TIMEOUT and timeout=1 with cycle_cnt=20. A hit on edge 20 instead gives DRAIN.
- Dual hit: both lanes hit on the same cycle, then a further hit during DRAIN.
  - Required: single latch with halt_instr including both lanes; later hits have no effect.
- Restart and async reset:
  - start in DONE clears the counters and returns to RUN.
  - start in RUN is ignored.
  - rst_n low mid-DRAIN zeroes all outputs without a clock edge.
- Saturation: CNT_WIDTH=4 with 2 commits/cycle.
  - Required: instr_cnt stops at 15; cycle_cnt stops at 15.
